// File: rtl/bcd_countdown_mmss_if.sv
// Control, load and status bundle of the BCD mm:ss countdown timer.
// The master drives the strobes and load digits. The slave (the timer) drives the digits and the status flags.
interface bcd_countdown_mmss_if;
    logic       tick;
    logic       load;
    logic [2:0] load_min10;
    logic [3:0] load_min;
    logic [2:0] load_sec10;
    logic [3:0] load_sec;
    logic       start;
    logic       pause;
    logic       stop;

    logic [2:0] min10;
    logic [3:0] min;
    logic [2:0] sec10;
    logic [3:0] sec;
    logic       running;
    logic       paused;
    logic       expired;
    logic       load_err;

    modport master (
        output tick, load, load_min10, load_min, load_sec10, load_sec,
               start, pause, stop,
        input  min10, min, sec10, sec, running, paused, expired, load_err
    );

    modport slave (
        input  tick, load, load_min10, load_min, load_sec10, load_sec,
               start, pause, stop,
        output min10, min, sec10, sec, running, paused, expired, load_err
    );
endinterface

// File: rtl/bcd_countdown_mmss.sv
// Loadable BCD minutes:seconds countdown timer. It counts down on tick strobes and pulses expired at 00:00.
// All state changes on the falling edge of clock, matching the companion mod-60 up-counter.
module bcd_countdown_mmss #(
    parameter int unsigned MIN_TENS_MAX = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bcd_countdown_mmss_if.slave  bus
);

    localparam logic [2:0] MIN10_LIMIT = 3'(MIN_TENS_MAX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    typedef struct packed {
        logic [2:0] min10;
        logic [3:0] min;
        logic [2:0] sec10;
        logic [3:0] sec;
    } mmss_t;

    state_t state_q, state_d;
    mmss_t  value_q, value_d;
    logic   expired_q, expired_d;
    logic   load_err_q, load_err_d;

    mmss_t  load_value;
    mmss_t  dec_value;
    logic   load_valid;
    logic   value_zero;
    logic   dec_zero;
    logic   can_load;
    logic   can_start;

    // A borrow ripples toward the minutes digits only when a lower digit is already zero.
    function automatic mmss_t decrement(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.sec != 4'd0) begin
            r.sec = v.sec - 4'd1;
        end else begin
            r.sec = 4'd9;
            if (v.sec10 != 3'd0) begin
                r.sec10 = v.sec10 - 3'd1;
            end else begin
                r.sec10 = 3'd5;
                if (v.min != 4'd0) begin
                    r.min = v.min - 4'd1;
                end else begin
                    r.min   = 4'd9;
                    r.min10 = v.min10 - 3'd1;
                end
            end
        end
        return r;
    endfunction

    assign load_value = '{min10: bus.load_min10, min: bus.load_min,
                          sec10: bus.load_sec10, sec: bus.load_sec};

    assign load_valid = (bus.load_min   <= 4'd9) &&
                        (bus.load_sec   <= 4'd9) &&
                        (bus.load_sec10 <= 3'd5) &&
                        (bus.load_min10 <= MIN10_LIMIT);

    assign value_zero = (value_q == '0);
    assign dec_value  = decrement(value_q);
    assign dec_zero   = (dec_value == '0);
    assign can_load   = (state_q != RUN);
    assign can_start  = (state_q == IDLE) || (state_q == PAUSED);

    // Next-state logic. The if/else chain encodes the per-edge priority: stop, then load, start, pause, tick.
    // A load in RUN is not accepted, so it falls through to the lower-priority strobes.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the chain leaves it unassigned (no latch).
        state_d    = state_q;
        value_d    = value_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.load && can_load) begin
            if (load_valid) begin
                value_d = load_value;
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.start && can_start) begin
            if (value_zero) begin
                state_d   = DONE;
                expired_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (bus.pause && (state_q == RUN)) begin
            state_d = PAUSED;
        end else if (bus.tick && (state_q == RUN)) begin
            value_d = dec_value;
            if (dec_zero) begin
                state_d   = DONE;
                expired_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            value_q    <= '0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.min10    = value_q.min10;
    assign bus.min      = value_q.min;
    assign bus.sec10    = value_q.sec10;
    assign bus.sec      = value_q.sec;
    assign bus.running  = (state_q == RUN);
    assign bus.paused   = (state_q == PAUSED);
    assign bus.expired  = expired_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_mmss.sv
// Self-checking bench for bcd_countdown_mmss. It runs directed vectors, multi-cycle sequences, and random stimulus.
// The random stimulus is checked against a model that keeps the timer value as a plain count of seconds.
module tb_bcd_countdown_mmss;

    localparam int MIN_TENS_MAX = 5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    bcd_countdown_mmss_if bus();

    bcd_countdown_mmss #(.MIN_TENS_MAX(MIN_TENS_MAX)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       rst;
        bit       tick;
        bit       load;
        bit [2:0] lm10;
        bit [3:0] lm;
        bit [2:0] ls10;
        bit [3:0] ls;
        bit       start;
        bit       pause;
        bit       stop;
    } stim_t;

    typedef struct {
        stim_t s;
        int    m10, m, s10, sc;
        int    run, pau, ex, err;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    // Reference model: the value is held as total seconds, and the state as a small integer.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int m_total = 0;
    int m_state = M_IDLE;
    int m_exp   = 0;
    int m_err   = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic stim_t mk(input string op, input int a = 0, input int b = 0,
                                 input int c = 0, input int d = 0);
        stim_t s;
        s = '{default: 0};
        s.lm10 = 3'(a);
        s.lm   = 4'(b);
        s.ls10 = 3'(c);
        s.ls   = 4'(d);
        case (op)
            "rst":       s.rst  = 1;
            "tick":      s.tick = 1;
            "load":      s.load = 1;
            "start":     s.start = 1;
            "pause":     s.pause = 1;
            "stop":      s.stop = 1;
            "loadstart": begin s.load = 1; s.start = 1; end
            "pausetick": begin s.pause = 1; s.tick = 1; end
            "loadtick":  begin s.load = 1; s.tick = 1; end
            default: ;
        endcase
        return s;
    endfunction

    // Drive the inputs just after a rising edge, let the DUT update on the falling edge,
    // and return at the next rising edge, where the outputs are stable for sampling.
    task automatic do_cycle(input stim_t s);
        reset_n        = !s.rst;
        bus.tick       = s.tick;
        bus.load       = s.load;
        bus.load_min10 = s.lm10;
        bus.load_min   = s.lm;
        bus.load_sec10 = s.ls10;
        bus.load_sec   = s.ls;
        bus.start      = s.start;
        bus.pause      = s.pause;
        bus.stop       = s.stop;
        @(negedge clock);
        @(posedge clock);
    endtask

    task automatic exp_out(input string name, input int m10, input int m, input int s10,
                           input int sc, input int run, input int pau, input int ex, input int err);
        check({name, ".min10"},    int'(bus.min10),    m10);
        check({name, ".min"},      int'(bus.min),      m);
        check({name, ".sec10"},    int'(bus.sec10),    s10);
        check({name, ".sec"},      int'(bus.sec),      sc);
        check({name, ".running"},  int'(bus.running),  run);
        check({name, ".paused"},   int'(bus.paused),   pau);
        check({name, ".expired"},  int'(bus.expired),  ex);
        check({name, ".load_err"}, int'(bus.load_err), err);
    endtask

    task automatic add(input stim_t s, input int m10, input int m, input int s10, input int sc,
                       input int run, input int pau, input int ex, input int err);
        vec_t v;
        v.s = s; v.m10 = m10; v.m = m; v.s10 = s10; v.sc = sc;
        v.run = run; v.pau = pau; v.ex = ex; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic model_step(input stim_t s);
        bit valid;
        m_exp = 0;
        m_err = 0;
        valid = (s.lm <= 9) && (s.ls <= 9) && (s.ls10 <= 5) && (s.lm10 <= MIN_TENS_MAX);
        if (s.rst) begin
            m_state = M_IDLE;
            m_total = 0;
        end else if (s.stop) begin
            m_state = M_IDLE;
        end else if (s.load && m_state != M_RUN) begin
            if (valid) begin
                m_total = s.lm10 * 600 + s.lm * 60 + s.ls10 * 10 + s.ls;
                m_state = M_IDLE;
            end else begin
                m_err = 1;
            end
        end else if (s.start && (m_state == M_IDLE || m_state == M_PAUSED)) begin
            if (m_total == 0) begin
                m_state = M_DONE;
                m_exp   = 1;
            end else begin
                m_state = M_RUN;
            end
        end else if (s.pause && m_state == M_RUN) begin
            m_state = M_PAUSED;
        end else if (s.tick && m_state == M_RUN) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
                m_state = M_DONE;
                m_exp   = 1;
            end
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        int t;
        s = '{default: 0};
        s.rst   = ($urandom_range(0, 199) == 0);
        s.stop  = ($urandom_range(0, 99) < 2);
        s.load  = ($urandom_range(0, 99) < 6);
        s.start = ($urandom_range(0, 99) < 10);
        s.pause = ($urandom_range(0, 99) < 6);
        s.tick  = ($urandom_range(0, 99) < 55);
        case ($urandom_range(0, 3))
            0, 1: begin
                t = $urandom_range(0, 25);
                s.lm10 = 3'(t / 600); s.lm = 4'((t / 60) % 10);
                s.ls10 = 3'((t % 60) / 10); s.ls = 4'(t % 10);
            end
            2: begin
                s.lm10 = 3'($urandom_range(0, 7)); s.lm = 4'($urandom_range(0, 15));
                s.ls10 = 3'($urandom_range(0, 7)); s.ls = 4'($urandom_range(0, 15));
            end
            default: begin
                s.lm10 = 3'(MIN_TENS_MAX); s.lm = 4'd0; s.ls10 = 3'd0;
                s.ls = 4'($urandom_range(0, 2));
            end
        endcase
        return s;
    endfunction

    initial begin
        // Directed table, hand-derived expectations: {m10,m,s10,s, running,paused,expired,load_err}
        add(mk("rst"),               0,0,0,0, 0,0,0,0);
        add(mk("load", 0,0,3,0),     0,0,3,0, 0,0,0,0);
        add(mk("start"),             0,0,3,0, 1,0,0,0);
        add(mk("tick"),              0,0,2,9, 1,0,0,0);
        add(mk("tick"),              0,0,2,8, 1,0,0,0);
        add(mk("tick"),              0,0,2,7, 1,0,0,0);
        add(mk("tick"),              0,0,2,6, 1,0,0,0);
        add(mk("tick"),              0,0,2,5, 1,0,0,0);
        add(mk("pausetick"),         0,0,2,5, 0,1,0,0);
        add(mk("tick"),              0,0,2,5, 0,1,0,0);
        add(mk("tick"),              0,0,2,5, 0,1,0,0);
        add(mk("tick"),              0,0,2,5, 0,1,0,0);
        add(mk("start"),             0,0,2,5, 1,0,0,0);
        add(mk("tick"),              0,0,2,4, 1,0,0,0);
        add(mk("stop"),              0,0,2,4, 0,0,0,0);
        add(mk("load", 0,0,6,0),     0,0,2,4, 0,0,0,1);
        add(mk("idle"),              0,0,2,4, 0,0,0,0);
        add(mk("load", 0,10,0,0),    0,0,2,4, 0,0,0,1);
        add(mk("load", 0,0,0,10),    0,0,2,4, 0,0,0,1);
        add(mk("start"),             0,0,2,4, 1,0,0,0);
        add(mk("load", 0,1,0,0),     0,0,2,4, 1,0,0,0);
        add(mk("loadtick", 0,1,0,0), 0,0,2,3, 1,0,0,0);
        add(mk("stop"),              0,0,2,3, 0,0,0,0);
        add(mk("load", 5,9,5,9),     5,9,5,9, 0,0,0,0);
        add(mk("load", 6,0,0,0),     5,9,5,9, 0,0,0,1);
        add(mk("load", 0,0,0,0),     0,0,0,0, 0,0,0,0);
        add(mk("start"),             0,0,0,0, 0,0,1,0);
        add(mk("idle"),              0,0,0,0, 0,0,0,0);
        add(mk("tick"),              0,0,0,0, 0,0,0,0);
        add(mk("start"),             0,0,0,0, 0,0,0,0);
        add(mk("load", 0,0,0,5),     0,0,0,5, 0,0,0,0);
        add(mk("loadstart", 0,0,0,7),0,0,0,7, 0,0,0,0);
        add(mk("start"),             0,0,0,7, 1,0,0,0);
        add(mk("start"),             0,0,0,7, 1,0,0,0);
        add(mk("pause"),             0,0,0,7, 0,1,0,0);
        add(mk("pause"),             0,0,0,7, 0,1,0,0);
        add(mk("load", 0,0,4,2),     0,0,4,2, 0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle(tbl[i].s);
            exp_out($sformatf("vec%0d", i), tbl[i].m10, tbl[i].m, tbl[i].s10, tbl[i].sc,
                    tbl[i].run, tbl[i].pau, tbl[i].ex, tbl[i].err);
        end

        // Sequence: 01:00 counts all the way down, with a single expired pulse.
        do_cycle(mk("rst"));
        do_cycle(mk("load", 0,1,0,0));
        do_cycle(mk("start"));
        do_cycle(mk("tick"));
        exp_out("seq1_first", 0,0,5,9, 1,0,0,0);
        for (int i = 0; i < 58; i++) do_cycle(mk("tick"));
        exp_out("seq1_last", 0,0,0,1, 1,0,0,0);
        do_cycle(mk("tick"));
        exp_out("seq1_zero", 0,0,0,0, 0,0,1,0);
        do_cycle(mk("idle"));
        exp_out("seq1_after", 0,0,0,0, 0,0,0,0);

        // Sequence: minutes-tens borrow, then a 00:10 countdown and ticks ignored in DONE.
        do_cycle(mk("load", 1,0,0,0));
        do_cycle(mk("start"));
        do_cycle(mk("tick"));
        exp_out("seq2_borrow", 0,9,5,9, 1,0,0,0);
        do_cycle(mk("pause"));
        do_cycle(mk("load", 0,0,1,0));
        do_cycle(mk("start"));
        for (int i = 0; i < 9; i++) do_cycle(mk("tick"));
        exp_out("seq2_one", 0,0,0,1, 1,0,0,0);
        do_cycle(mk("tick"));
        exp_out("seq2_expire", 0,0,0,0, 0,0,1,0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(mk("tick"));
            exp_out($sformatf("seq2_done%0d", i), 0,0,0,0, 0,0,0,0);
        end

        // Sequence: reset mid-RUN; then stop mid-RUN keeps the digits and start resumes.
        do_cycle(mk("load", 0,3,1,5));
        do_cycle(mk("start"));
        exp_out("seq6_run", 0,3,1,5, 1,0,0,0);
        do_cycle(mk("rst"));
        exp_out("seq6_reset", 0,0,0,0, 0,0,0,0);
        do_cycle(mk("load", 0,3,1,5));
        do_cycle(mk("start"));
        do_cycle(mk("stop"));
        exp_out("seq6_stop", 0,3,1,5, 0,0,0,0);
        do_cycle(mk("start"));
        do_cycle(mk("tick"));
        exp_out("seq6_resume", 0,3,1,4, 1,0,0,0);

        // Random stimulus compared against the seconds-count model.
        begin
            stim_t s;
            s = mk("rst");
            model_step(s);
            do_cycle(s);
            for (int i = 0; i < 4000; i++) begin
                s = rand_stim();
                model_step(s);
                do_cycle(s);
                exp_out($sformatf("rnd%0d", i), m_total / 600, (m_total / 60) % 10,
                        (m_total % 60) / 10, m_total % 10,
                        int'(m_state == M_RUN), int'(m_state == M_PAUSED), m_exp, m_err);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_mmss.md
Name: bcd_countdown_mmss

Overview:
- Loadable BCD minutes:seconds countdown timer.
- It is the down-counting counterpart of the team's mod-60 BCD up-counter, and uses the same digit widths (3-bit tens, 4-bit units).
- A 1-cycle tick strobe from the timebase decrements the value. Control inputs load, start, pause and stop drive a small state machine.
- On reaching 00:00 the block raises a one-cycle expired pulse for the alarm/display logic.

Parameters:
- MIN_TENS_MAX, 5, largest legal minutes-tens digit (0..7). Bounds load validation and the minutes range.

Ports:
- clock  input  1  system clock; all state updates on the falling edge, like the companion counter.
- reset_n  input  1  synchronous, active-low reset, sampled on the falling edge of clock.
- tick  input  1  decrement strobe, one clock wide.
- load  input  1  load request strobe.
- load_min10  input  3  minutes tens digit to load.
- load_min  input  4  minutes units digit to load.
- load_sec10  input  3  seconds tens digit to load.
- load_sec  input  4  seconds units digit to load.
- start  input  1  start or resume strobe.
- pause  input  1  pause strobe.
- stop  input  1  abort to IDLE; digits are kept.
- min10  output  3  current minutes tens digit.
- min  output  4  current minutes units digit.
- sec10  output  3  current seconds tens digit.
- sec  output  4  current seconds units digit.
- running  output  1  high in RUN.
- paused  output  1  high in PAUSED.
- expired  output  1  one-cycle pulse on reaching 00:00.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:

Reset:
- reset_n=0 at an edge forces state IDLE and all digits 0.
- running, paused, expired and load_err all go to 0.
- Reset overrides every other input, including mid-RUN.

States and transitions:
- States: IDLE, RUN, PAUSED, DONE.
- IDLE/PAUSED/DONE + load with valid digits: load the digits; next state IDLE.
- IDLE/PAUSED/DONE + load with invalid digits: digits unchanged, state unchanged, load_err=1 for one cycle.
- A load digit is invalid if min>9, sec>9, sec10>5 or min10>MIN_TENS_MAX.
- load is ignored in RUN.
- IDLE/PAUSED + start (no load), value nonzero: go to RUN.
- IDLE/PAUSED + start (no load), value 00:00: go to DONE and pulse expired.
- RUN + pause: go to PAUSED. A tick on the same edge is ignored (pause wins).
- stop in any state: go to IDLE with digits held.
- Priority within one edge: reset_n > stop > load > start > pause > tick.
- start in RUN/DONE has no effect; pause outside RUN has no effect.

Decrement (RUN and tick only):
- sec>0: sec-1.
- Else sec=9, and:
  - sec10>0: sec10-1.
  - Else sec10=5, and:
    - min>0: min-1.
    - Else min=9 and min10-1.
- The RUN-and-tick condition cannot occur at 00:00, because the transition into 00:00 leaves RUN.

Expiry:
- If the decremented value is 00:00, state goes to DONE on the same edge.
- expired is registered: high for exactly one cycle following that edge.
- DONE holds 00:00 until load or stop. Ticks in IDLE/PAUSED/DONE are ignored.

Outputs:
- All outputs are registered; latency is one edge from the input.
- running and paused reflect the state after the edge.
- Digits always hold legal BCD, so the max value is MIN_TENS_MAX9:59.

Test Plan:
1. Reset, then load 01:00, start, one tick -> 00:59. Then 58 ticks -> 00:01. One more tick -> 00:00, DONE, expired high for exactly 1 cycle, running=0.
2. Load 10:00, start, one tick -> 09:59. Load 00:10, start, 10 ticks -> expired. Continued ticks in DONE leave 00:00 and produce no extra expired.
3. Load 00:30, start, 5 ticks -> 00:25. Pause with a simultaneous tick -> 00:25, paused=1. 3 ticks -> still 00:25. Start, 1 tick -> 00:24.
4. Load sec10=6 (digits 0,0,6,0) -> load_err 1 cycle, digits unchanged. Load min=0xA -> load_err. Load during RUN -> ignored, no load_err. Load 59:59 -> accepted.
5. Load 00:00, start -> DONE with expired pulse. Load 00:05 in DONE -> IDLE, 00:05. Same-edge load 00:07 + start in IDLE -> IDLE, 00:07, not running.
6. Mid-RUN at 03:15, assert reset_n=0 for one edge -> 00:00, IDLE, all flags 0. Separately, stop mid-RUN at 03:15 -> IDLE with 03:15 held; start resumes from 03:15.
